// File: rtl/entropy_encoding_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entropy_encoding_pkg                                                       |
// | Shared types, symbol constants and zigzag table for the entropy encoder.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package entropy_encoding_pkg;

    // Huffman code, right-aligned in code, length 1..16 in len.
    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
    } huff_enc_entry_t;

    localparam logic [7:0] SYM_EOB = 8'h00;
    localparam logic [7:0] SYM_ZRL = 8'hF0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ZRL   = 3'd2,
        ST_HUFF  = 3'd3,
        ST_VLI   = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_FLUSH = 3'd7
    } enc_state_t;

    // Row-major block position of each zigzag index.
    localparam logic [5:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Bit length of a magnitude in 0..2047.
    function automatic logic [3:0] coef_size(input logic [11:0] mag);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (mag[i]) s = 4'(i + 1);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/entropy_encoding_bit_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entropy_encoding_bit_packer                                                |
// | MSB-first bit accumulator with append, ones-padding and word handshake.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module entropy_encoding_bit_packer #(
    parameter int OUT_W = 32,
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             app_valid,
    input  logic [15:0]      app_bits,
    input  logic [4:0]       app_len,
    output logic             app_ready,
    input  logic             pad_valid,
    output logic             empty,
    output logic             partial,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             out_ready
);
    localparam int CW = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] r_acc;
    logic [CW-1:0]    r_count;

    logic             w_drain;
    logic             w_app_fire;
    logic [ACC_W-1:0] w_base_acc;
    logic [CW-1:0]    w_base_cnt;
    logic [15:0]      w_mask;
    logic [ACC_W-1:0] w_bits;
    logic [CW-1:0]    w_shamt;
    logic [ACC_W-1:0] w_pad_mask;

    assign valid_out = (r_count >= CW'(OUT_W));
    assign data_out  = valid_out ? r_acc[ACC_W-1 -: OUT_W] : '0;
    assign app_ready = (r_count <= CW'(ACC_W - 16));
    assign empty     = (r_count == '0);
    assign partial   = (r_count < CW'(OUT_W));

    assign w_drain    = valid_out && out_ready;
    assign w_app_fire = app_valid && app_ready;
    assign w_base_acc = w_drain ? (r_acc << OUT_W) : r_acc;
    assign w_base_cnt = w_drain ? (r_count - CW'(OUT_W)) : r_count;
    assign w_mask     = 16'hFFFF >> (5'd16 - app_len);
    assign w_bits     = {{(ACC_W-16){1'b0}}, app_bits & w_mask};
    // New bits land directly below the bits still held after this cycle's drain.
    assign w_shamt    = CW'(ACC_W) - w_base_cnt - CW'(app_len);
    assign w_pad_mask = ({ACC_W{1'b1}} >> r_count) & ~({ACC_W{1'b1}} >> OUT_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (pad_valid && partial && !empty) begin
            r_acc   <= r_acc | w_pad_mask;
            r_count <= CW'(OUT_W);
        end else begin
            r_acc   <= w_base_acc | (w_app_fire ? (w_bits << w_shamt) : '0);
            r_count <= w_base_cnt + (w_app_fire ? CW'(app_len) : '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/entropy_encoding.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | entropy_encoding                                                           |
// | Zigzag scan, run-length/VLI and Huffman coding of one 8x8 block per accept.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module entropy_encoding
    import entropy_encoding_pkg::*;
#(
    parameter int OUT_BUS_WIDTH = 32,
    parameter int ACC_W         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0][7:0][11:0]    block,
    input  logic                     valid_in,
    input  logic                     last_in,
    input  huff_enc_entry_t [255:0]  enc_tab,
    output logic                     in_ready,
    output logic [OUT_BUS_WIDTH-1:0] data_out,
    output logic                     valid_out,
    input  logic                     out_ready
);
    enc_state_t            r_state;
    enc_state_t            w_state_nxt;
    logic [7:0][7:0][11:0] r_block;
    logic                  r_last;
    logic                  r_started;
    logic [5:0]            r_idx;
    logic [5:0]            r_run;
    logic [11:0]           r_coef;
    logic [3:0]            r_size;

    logic [5:0]            w_pos;
    logic [11:0]           w_raw;
    logic [11:0]           w_sat;
    logic [11:0]           w_mag;
    logic [3:0]            w_size;
    logic [11:0]           w_vli;
    logic                  w_zero_ac;

    logic                  w_app_valid;
    logic [15:0]           w_app_bits;
    logic [4:0]            w_app_len;
    logic                  w_app_ready;
    logic                  w_pad;
    logic                  w_pk_empty;
    logic                  w_pk_partial;

    assign in_ready  = (r_state == ST_IDLE) && r_started;

    assign w_pos     = ZIGZAG[r_idx];
    assign w_raw     = r_block[w_pos[5:3]][w_pos[2:0]];
    assign w_sat     = (w_raw == 12'h800) ? 12'h801 : w_raw;
    assign w_mag     = w_sat[11] ? 12'(-w_sat) : w_sat;
    assign w_size    = coef_size(w_mag);
    assign w_zero_ac = (r_idx != 6'd0) && (w_mag == 12'd0);
    // Negative values are sent as the low bits of v-1 (one's complement form).
    assign w_vli     = r_coef[11] ? (r_coef - 12'd1) : r_coef;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_app_valid = 1'b0;
        w_app_bits  = 16'd0;
        w_app_len   = 5'd0;
        w_pad       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_in && in_ready) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (w_zero_ac) begin
                    if (r_idx == 6'd63) w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = (r_run > 6'd15) ? ST_ZRL : ST_HUFF;
                end
            end
            ST_ZRL: begin
                w_app_valid = 1'b1;
                w_app_bits  = enc_tab[SYM_ZRL].code;
                w_app_len   = enc_tab[SYM_ZRL].len;
                if (w_app_ready && (r_run < 6'd32)) w_state_nxt = ST_HUFF;
            end
            ST_HUFF: begin
                w_app_valid = 1'b1;
                w_app_bits  = enc_tab[{r_run[3:0], r_size}].code;
                w_app_len   = enc_tab[{r_run[3:0], r_size}].len;
                if (w_app_ready) w_state_nxt = (r_size != 4'd0) ? ST_VLI : ST_NEXT;
            end
            ST_VLI: begin
                w_app_valid = 1'b1;
                w_app_bits  = {4'b0000, w_vli};
                w_app_len   = {1'b0, r_size};
                if (w_app_ready) w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                w_state_nxt = (r_idx == 6'd63) ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                if (r_run != 6'd0) begin
                    w_app_valid = 1'b1;
                    w_app_bits  = enc_tab[SYM_EOB].code;
                    w_app_len   = enc_tab[SYM_EOB].len;
                    if (w_app_ready) w_state_nxt = r_last ? ST_FLUSH : ST_IDLE;
                end else begin
                    w_state_nxt = r_last ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Pad only once full words are gone, so the pad never exceeds one word.
                if (w_pk_empty) w_state_nxt = ST_IDLE;
                else if (w_pk_partial) w_pad = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_block   <= '0;
            r_last    <= 1'b0;
            r_started <= 1'b0;
            r_idx     <= 6'd0;
            r_run     <= 6'd0;
            r_coef    <= 12'd0;
            r_size    <= 4'd0;
        end else begin
            r_started <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (valid_in && in_ready) begin
                        r_block <= block;
                        r_last  <= last_in;
                        r_idx   <= 6'd0;
                        r_run   <= 6'd0;
                    end
                end
                ST_SCAN: begin
                    if (w_zero_ac) begin
                        r_run <= r_run + 6'd1;
                        if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
                    end else begin
                        r_coef <= w_sat;
                        r_size <= w_size;
                    end
                end
                ST_ZRL: begin
                    if (w_app_ready) r_run <= r_run - 6'd16;
                end
                ST_VLI: begin
                    if (w_app_ready) r_run <= 6'd0;
                end
                ST_NEXT: begin
                    if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
                end
                ST_DONE: begin
                    if (w_app_ready) r_run <= 6'd0;
                end
                default: ;
            endcase
        end
    end

    entropy_encoding_bit_packer #(
        .OUT_W (OUT_BUS_WIDTH),
        .ACC_W (ACC_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .app_valid (w_app_valid),
        .app_bits  (w_app_bits),
        .app_len   (w_app_len),
        .app_ready (w_app_ready),
        .pad_valid (w_pad),
        .empty     (w_pk_empty),
        .partial   (w_pk_partial),
        .data_out  (data_out),
        .valid_out (valid_out),
        .out_ready (out_ready)
    );

endmodule
`default_nettype wire
